// File: rtl/ram_loader_ctrl.sv
// ram_loader_ctrl: program-load controller for the shared on-chip RAM.
// Reads a 16-bit big-endian word count followed by big-endian 32-bit words
// from a byte FIFO and writes them to RAM word addresses 0..N-1. The CPU is
// held stalled for the whole load. If anything goes wrong, it stays stalled.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing byte equal
// to the XOR of all data bytes before the image is accepted.
module ram_loader_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [7:0]        fifo_dout_i,
  output logic              stall_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] words_o
);

  // A word count that reaches the GPIO word address (2^ADDR_W-1) is rejected.
  localparam logic [31:0] N_LIMIT = 32'((64'd1 << ADDR_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_e;

  state_e            state_q;
  logic              rd_q;      // read strobe is on the FIFO this cycle
  logic              pend_q;    // FIFO data for the last strobe is valid now
  logic              stall_q, we_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] words_q, addr_q;
  logic [31:0]       data_q;
  logic [23:0]       acc_q;     // first three bytes of the word in progress
  logic [1:0]        byte_idx_q;
  logic [15:0]       n_q;
  logic [7:0]        csum_q;
  logic [31:0]       to_q;

  logic        fetch_st_s, cap_s, issue_s, to_hit_s;
  logic [15:0] hdr_n_s;

`ifdef LOADER_CHECKSUM_EN
  assign fetch_st_s = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
`else
  assign fetch_st_s = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA);
`endif
  assign cap_s    = pend_q;
  assign issue_s  = !rd_q && !pend_q && !fifo_empty_i;
  assign to_hit_s = (TIMEOUT_CYC != 32'd0) && !rd_q && !pend_q &&
                    ((to_q + 32'd1) >= TIMEOUT_CYC);
  assign hdr_n_s  = {n_q[15:8], fifo_dout_i};

  // Load sequencer: byte fetch, header parse, word assembly, RAM write, status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      pend_q     <= 1'b0;
      stall_q    <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      acc_q      <= 24'd0;
      byte_idx_q <= 2'd0;
      n_q        <= 16'd0;
      csum_q     <= 8'd0;
      to_q       <= 32'd0;
    end else begin
      rd_q   <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      pend_q <= rd_q;
      if (!fetch_st_s || cap_s) begin
        to_q <= 32'd0;
      end else begin
        to_q <= to_q + 32'd1;
      end
      case (state_q)
        S_IDLE, S_ERR: begin
          if (load_start_i) begin
            state_q    <= S_HDR_HI;
            stall_q    <= 1'b1;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            words_q    <= '0;
            csum_q     <= 8'd0;
            byte_idx_q <= 2'd0;
          end
        end
        S_HDR_HI: begin
          if (cap_s) begin
            n_q[15:8] <= fifo_dout_i;
            state_q   <= S_HDR_LO;
            rd_q      <= !fifo_empty_i;
          end else if (to_hit_s) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            rd_q <= issue_s;
          end
        end
        S_HDR_LO: begin
          if (cap_s) begin
            n_q <= hdr_n_s;
            if (32'(hdr_n_s) >= N_LIMIT) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else if (hdr_n_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= S_CSUM;
              rd_q    <= !fifo_empty_i;
`else
              state_q <= S_DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= S_DATA;
              rd_q    <= !fifo_empty_i;
            end
          end else if (to_hit_s) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            rd_q <= issue_s;
          end
        end
        S_DATA: begin
          if (cap_s) begin
            csum_q     <= csum_q ^ fifo_dout_i;
            acc_q      <= {acc_q[15:0], fifo_dout_i};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= words_q;
              data_q  <= {acc_q, fifo_dout_i};
              words_q <= words_q + ADDR_W'(1);
              state_q <= S_WRITE;
            end else begin
              rd_q <= !fifo_empty_i;
            end
          end else if (to_hit_s) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            rd_q <= issue_s;
          end
        end
        S_WRITE: begin
          // words_q already counts the word being written this cycle; the
          // next byte is requested here so a word takes 9 cycles end to end.
          if (32'(words_q) == 32'(n_q)) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= S_CSUM;
            rd_q    <= !fifo_empty_i;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q <= S_DATA;
            rd_q    <= !fifo_empty_i;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (cap_s) begin
            if (fifo_dout_i == csum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else if (to_hit_s) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            rd_q <= issue_s;
          end
        end
`endif
        S_DONE: begin
          stall_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en_o = rd_q;
  assign stall_o      = stall_q;
  assign ram_we_o     = we_q;
  assign ram_addr_o   = addr_q;
  assign ram_data_o   = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_o      = words_q;

endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Self-checking bench for ram_loader_ctrl: FIFO model, write monitor and an
// image-level reference model (header + words + optional XOR byte).
`timescale 1ns/1ps
module tb_ram_loader_ctrl;
  localparam int AW = 16;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic fifo_empty, fifo_rd_en, stall, ram_we, busy, done, err;
  logic [7:0] fifo_dout;
  logic [AW-1:0] ram_addr, words;
  logic [31:0] ram_data;

  ram_loader_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_start_i(load_start),
    .fifo_empty_i(fifo_empty), .fifo_rd_en_o(fifo_rd_en), .fifo_dout_i(fifo_dout),
    .stall_o(stall), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data),
    .busy_o(busy), .done_o(done), .err_o(err), .words_o(words)
  );

  always #5 clk = ~clk;

  // Byte FIFO: data appears on the cycle after the read strobe.
  logic [7:0] img [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int last_pop = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= img[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
      last_pop  <= cyc;
    end
  end

  // Output monitors.
  int wr_cnt = 0, done_cnt = 0, stall_cnt = 0, rd_cnt = 0, rd_in_err = 0;
  logic [AW-1:0] wr_addr [0:255];
  logic [31:0]   wr_data [0:255];
  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr[wr_cnt % 256] <= ram_addr;
      wr_data[wr_cnt % 256] <= ram_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (stall) stall_cnt <= stall_cnt + 1;
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (fifo_rd_en && err) rd_in_err <= rd_in_err + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_we"},    32'(ram_we), 32'd0);
    check({tag, "_rd"},    32'(fifo_rd_en), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_words"}, 32'(words), 32'd0);
    check({tag, "_addr"},  32'(ram_addr), 32'd0);
    check({tag, "_data"},  ram_data, 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    img[wr_ptr % 1024] = b;
    wr_ptr++;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic pulse_start();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
  endtask

  // Wait for done or err; records the cycle the outcome was first seen.
  task automatic wait_end(input string tag, input int max, output int seen_cyc);
    bit seen = 1'b0;
    seen_cyc = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done || err) begin
        seen = 1'b1;
        seen_cyc = cyc;
      end
    end
    check({tag, "_end_seen"}, 32'(seen), 32'd1);
  endtask

  // Reference model: byte stream = count MSB, count LSB, each word MSB first,
  // then (checksum build) XOR of all data bytes. Expect writes 0..N-1 in order.
  task automatic run_image(input string tag, input logic [31:0] ws[$],
                           input int gap_max, input bit preload, input bit chk_stall);
    logic [7:0] bytes[$];
    logic [7:0] x = 8'h00;
    int n = ws.size();
    int base_wr, base_done, base_stall, t_end, extra;
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    foreach (ws[i]) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b = ws[i][31 - 8*k -: 8];
        bytes.push_back(b);
        x ^= b;
      end
    end
    extra = 0;
`ifdef LOADER_CHECKSUM_EN
    bytes.push_back(x);
    extra = 2;
`endif
    base_wr = wr_cnt; base_done = done_cnt; base_stall = stall_cnt;
    if (preload) foreach (bytes[i]) push_byte(bytes[i]);
    pulse_start();
    check({tag, "_stall_rise"}, 32'(stall), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (!preload) begin
      foreach (bytes[i]) begin
        push_byte(bytes[i]);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
    end
    wait_end(tag, 2000, t_end);
    repeat (3) @(negedge clk);
    check({tag, "_nwr"}, 32'(wr_cnt - base_wr), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[(base_wr + i) % 256]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), wr_data[(base_wr + i) % 256], ws[i]);
    end
    check({tag, "_words"}, 32'(words), 32'(n));
    check({tag, "_done_cnt"}, 32'(done_cnt - base_done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_stall_end"}, 32'(stall), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    // Full FIFO: 1 start cycle + 2 header bytes at 2 cycles + DONE, then 9/word.
    if (chk_stall)
      check({tag, "_stall_len"}, 32'(stall_cnt - base_stall), 32'(6 + 9*n + extra));
  endtask

  initial begin
    logic [31:0] ws[$];
    logic [31:0] none[$];
    int base_wr, base_done, base_rd, base_rerr, t_end;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed two-word image.
    ws = '{32'hDEADBEEF, 32'h01234567};
    run_image("two_words", ws, 0, 1'b1, 1'b1);

    // Empty image.
    run_image("empty", none, 0, 1'b1, 1'b1);

    // Oversized header: error, stays stalled, never reads in ERR.
    base_wr = wr_cnt; base_done = done_cnt; base_rerr = rd_in_err;
    push_byte(8'hFF); push_byte(8'hFF);
    pulse_start();
    wait_end("hdr_ff", 200, t_end);
    repeat (5) @(negedge clk);
    check("hdr_ff_err", 32'(err), 32'd1);
    check("hdr_ff_stall", 32'(stall), 32'd1);
    check("hdr_ff_busy", 32'(busy), 32'd0);
    check("hdr_ff_nwr", 32'(wr_cnt - base_wr), 32'd0);
    check("hdr_ff_done", 32'(done_cnt - base_done), 32'd0);
    check("hdr_ff_rd_in_err", 32'(rd_in_err - base_rerr), 32'd0);
    flush();
    ws = '{$urandom, $urandom};
    run_image("err_restart", ws, 0, 1'b1, 1'b0);

    // Starvation after 2 data bytes: ERR TIMEOUT cycles after the last capture.
    flush();
    base_wr = wr_cnt;
    push_byte(8'h00); push_byte(8'h01); push_byte(8'hAA); push_byte(8'hBB);
    pulse_start();
    wait_end("starve", 400, t_end);
    repeat (2) @(negedge clk);
    check("starve_err", 32'(err), 32'd1);
    check("starve_stall", 32'(stall), 32'd1);
    check("starve_nwr", 32'(wr_cnt - base_wr), 32'd0);
    // capture is one edge after the pop, ERR TO edges later, seen one count on.
    check("starve_delay", 32'(t_end - last_pop), 32'(TO + 2));
    flush();

    // Reset in the middle of a word.
    push_byte(8'h00); push_byte(8'h03);
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    pulse_start();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    base_rd = rd_cnt; base_wr = wr_cnt;
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_rd", 32'(rd_cnt - base_rd), 32'd0);
    check("midrst_wr", 32'(wr_cnt - base_wr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    flush();

`ifdef LOADER_CHECKSUM_EN
    ws = '{32'h11223344};
    run_image("csum_ok", ws, 0, 1'b1, 1'b1);
    base_done = done_cnt;
    push_byte(8'h00); push_byte(8'h01); push_byte(8'h11);
    push_byte(8'h22); push_byte(8'h33); push_byte(8'h44); push_byte(8'h45);
    pulse_start();
    wait_end("csum_bad", 200, t_end);
    repeat (2) @(negedge clk);
    check("csum_bad_err", 32'(err), 32'd1);
    check("csum_bad_stall", 32'(stall), 32'd1);
    check("csum_bad_done", 32'(done_cnt - base_done), 32'd0);
    flush();
`endif

    // Randomized images, alternating preloaded and trickle-fed FIFO.
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 5);
      ws.delete();
      for (int i = 0; i < n; i++) ws.push_back($urandom);
      run_image($sformatf("rand%0d", t), ws, 4, (t % 2) == 0, (t % 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
